// File: rtl/mem_access.sv
// mem_access -- memory-stage access controller.
//
// Consumes the EX/MEM register outputs. Instructions without a memory or IO
// request pass straight through to MEM/WB with no added latency. A request
// (R > W > in > out) is turned into a single req/ack transaction on the
// shared data bus. The pipeline is held through stallreq_mem while the
// transaction is in flight, then the write-back triple is presented for one
// cycle in DONE.
//
// Bus handshake: bus_req is registered and, once raised, stays high with
// bus_addr/bus_wdata/bus_we/bus_sel frozen until the cycle in which bus_ack
// is sampled high (the transfer completes on that edge, bus_rdata is taken
// in the same cycle) or until TIMEOUT request cycles pass without ack.
// bus_ack is ignored whenever the controller is not requesting.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   mem_wd/wreg/wdata destination, write enable, ALU result / store data
//   mem_R/W/in/out    request flags
//   mem_addr          RAM byte address or IO port number
//   bus_*             shared data bus (req/we/sel/addr/wdata out, ack/rdata in)
//   stallreq_mem      pipeline stall request
//   wd_o/wreg_o/wdata_o  write-back triple to MEM/WB
//   bus_err           one-cycle pulse in DONE after a timed-out access
//   state_o           current FSM state (IDLE=0, REQ=1, DONE=2) for debug
module mem_access #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic        mem_W,
  input  logic        mem_R,
  input  logic        mem_in,
  input  logic        mem_out,
  input  logic [31:0] mem_addr,
  output logic        bus_req,
  output logic        bus_we,
  output logic        bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stallreq_mem,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        bus_err,
  output logic [1:0]  state_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic          req_q, req_d;
  logic          we_q, we_d;
  logic          sel_q, sel_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdat_q, wdat_d;
  logic [31:0]   rdbuf_q, rdbuf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic acc;
  logic req_we;
  logic req_sel;
  logic ack_hit;
  logic to_hit;
  logic stall_raw;

  assign acc = mem_R | mem_W | mem_in | mem_out;

  // Priority decode R > W > in > out: only the winning flag sets we/sel.
  assign req_we  = ~mem_R & (mem_W | (~mem_in & mem_out));
  assign req_sel = ~mem_R & ~mem_W & (mem_in | mem_out);

  // Ack wins over a timeout landing in the same cycle.
  assign ack_hit = (state_q == REQ) & bus_ack;
  assign to_hit  = (state_q == REQ) & ~bus_ack & (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc) state_d = REQ;
      REQ:     if (ack_hit || to_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    req_d   = req_q;
    we_d    = we_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rdbuf_d = rdbuf_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (acc) begin
          req_d  = 1'b1;
          we_d   = req_we;
          sel_d  = req_sel;
          addr_d = mem_addr;
          wdat_d = mem_wdata;
          cnt_d  = '0;
          err_d  = 1'b0;
        end
      end
      REQ: begin
        if (ack_hit) begin
          rdbuf_d = bus_rdata;
          req_d   = 1'b0;
        end else if (to_hit) begin
          rdbuf_d = '0;
          err_d   = 1'b1;
          req_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        err_d = 1'b0;
      end
      default: begin
        req_d = 1'b0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      rdbuf_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      req_q   <= req_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rdbuf_q <= rdbuf_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Output logic
  always_comb begin
    wd_o      = mem_wd;
    wreg_o    = mem_wreg;
    wdata_o   = mem_wdata;
    stall_raw = 1'b0;
    bus_err   = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc) begin
          stall_raw = 1'b1;
          wreg_o    = 1'b0;
        end
      end
      REQ: begin
        stall_raw = 1'b1;
        wreg_o    = 1'b0;
      end
      DONE: begin
        // Reads (R/in) were latched with we=0 and return the captured data.
        if (!we_q) wdata_o = rdbuf_q;
        bus_err = err_q;
      end
      default: begin
        wreg_o = 1'b0;
      end
    endcase
  end

  // The stall is released the moment reset is applied, not one edge later.
  assign stallreq_mem = stall_raw & ~rst;

  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_sel   = sel_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdat_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_W, mem_R, mem_in, mem_out;
  logic [31:0] mem_addr;
  logic        bus_req, bus_we, bus_sel;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        stallreq_mem;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        bus_err;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;

  // Scoreboard entries: {bus_err, wdata_o} expected in the DONE cycle.
  logic [32:0] exp_q[$];
  logic        prev_stall = 1'b0;

  // Observations filled in by do_access.
  int          obs_req, obs_stall;
  logic        obs_first_req, obs_wreg_busy, obs_stable, obs_hang;
  logic        obs_we, obs_sel;
  logic [31:0] obs_addr, obs_wdata;
  logic [4:0]  obs_done_wd;
  logic        obs_done_wreg;

  mem_access #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_W(mem_W), .mem_R(mem_R), .mem_in(mem_in), .mem_out(mem_out),
    .mem_addr(mem_addr),
    .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stallreq_mem(stallreq_mem),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .bus_err(bus_err), .state_o(state_o)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Scoreboard: the first non-stalled cycle after a stall is DONE.
  always @(negedge clk) begin
    if (!rst && prev_stall && !stallreq_mem) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: DONE seen with wdata_o=%h bus_err=%b, nothing expected", wdata_o, bus_err);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({bus_err, wdata_o} !== e) begin
          errors++;
          $display("FAIL sb_done: got err=%b wdata=%h want err=%b wdata=%h", bus_err, wdata_o, e[32], e[31:0]);
        end
      end
    end
    prev_stall = rst ? 1'b0 : stallreq_mem;
  end

  // Driver: call at posedge+1; returns at posedge+1 after DONE.
  // ack_wait = number of REQ cycles before ack (-1: never ack).
  task automatic do_access(input logic r, input logic w, input logic fi, input logic fo,
                           input logic [31:0] addr, input logic [31:0] wdat,
                           input logic [4:0] wd, input logic wreg,
                           input int ack_wait, input logic [31:0] rdata);
    int   n;
    logic done;
    mem_R = r; mem_W = w; mem_in = fi; mem_out = fo;
    mem_addr = addr; mem_wdata = wdat; mem_wd = wd; mem_wreg = wreg;
    obs_req = 0; obs_stall = 0; obs_wreg_busy = 1'b0; obs_stable = 1'b1;
    obs_first_req = 1'b0; done = 1'b0; n = 0;
    while (!done && n < 64) begin
      @(negedge clk);
      n++;
      if (n == 1) obs_first_req = bus_req;
      bus_ack = 1'b0;
      bus_rdata = $urandom();
      if (!stallreq_mem) begin
        done = 1'b1;
        obs_done_wd = wd_o;
        obs_done_wreg = wreg_o;
      end else begin
        obs_stall++;
        if (wreg_o) obs_wreg_busy = 1'b1;
        if (bus_req) begin
          obs_req++;
          if (obs_req == 1) begin
            obs_we = bus_we; obs_sel = bus_sel; obs_addr = bus_addr; obs_wdata = bus_wdata;
          end else if ({bus_we, bus_sel, bus_addr, bus_wdata} !== {obs_we, obs_sel, obs_addr, obs_wdata}) begin
            obs_stable = 1'b0;
          end
          if (obs_req - 1 == ack_wait) begin
            bus_ack = 1'b1;
            bus_rdata = rdata;
          end
        end
      end
    end
    obs_hang = !done;
    @(posedge clk);
    #1;
    mem_R = 1'b0; mem_W = 1'b0; mem_in = 1'b0; mem_out = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_wd = '0; mem_wreg = 1'b0; mem_wdata = '0; mem_addr = '0;
    mem_W = 1'b0; mem_R = 1'b0; mem_in = 1'b0; mem_out = 1'b0;
    bus_ack = 1'b0; bus_rdata = '0;
    #2;
    checks++;
    if ({bus_req, bus_we, bus_sel} !== 3'b000) begin
      errors++; $display("FAIL rst_bus_ctl: got %b want 000", {bus_req, bus_we, bus_sel});
    end
    checks++;
    if ({bus_addr, bus_wdata} !== 64'h0) begin
      errors++; $display("FAIL rst_bus_data: got addr=%h wdata=%h want 0", bus_addr, bus_wdata);
    end
    checks++;
    if ({stallreq_mem, bus_err, state_o} !== 4'b0000) begin
      errors++; $display("FAIL rst_state: got stall=%b err=%b state=%0d want 0", stallreq_mem, bus_err, state_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_passthrough();
    mem_wd = 5'd3; mem_wreg = 1'b1; mem_wdata = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      // Stray ack while idle must be ignored.
      bus_ack = (i == 1);
      checks++;
      if ({wd_o, wreg_o, wdata_o} !== {5'd3, 1'b1, 32'h1234}) begin
        errors++; $display("FAIL pass_wb: got wd=%0d wreg=%b wdata=%h want 3 1 00001234", wd_o, wreg_o, wdata_o);
      end
      checks++;
      if ({stallreq_mem, bus_req} !== 2'b00) begin
        errors++; $display("FAIL pass_stall: got stall=%b req=%b want 0 0", stallreq_mem, bus_req);
      end
    end
    bus_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_req, state_o} !== 3'b000) begin
      errors++; $display("FAIL pass_ack_ignored: got req=%b state=%0d want 0 0", bus_req, state_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_load();
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    do_access(1, 0, 0, 0, 32'h40, 32'h0, 5'd5, 1'b1, 2, 32'hDEADBEEF);
    checks++;
    if (obs_hang || obs_req != 3 || obs_stall != 4) begin
      errors++; $display("FAIL load_cycles: got req=%0d stall=%0d hang=%b want 3 4 0", obs_req, obs_stall, obs_hang);
    end
    checks++;
    if ({obs_addr, obs_we, obs_sel, obs_stable} !== {32'h40, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL load_bus: got addr=%h we=%b sel=%b stable=%b want 40 0 0 1", obs_addr, obs_we, obs_sel, obs_stable);
    end
    checks++;
    if ({obs_wreg_busy, obs_done_wreg, obs_done_wd} !== {1'b0, 1'b1, 5'd5}) begin
      errors++; $display("FAIL load_wb: got busy_wreg=%b wreg=%b wd=%0d want 0 1 5", obs_wreg_busy, obs_done_wreg, obs_done_wd);
    end
  endtask

  task automatic test_store();
    exp_q.push_back({1'b0, 32'hA5A5A5A5});
    do_access(0, 1, 0, 0, 32'h10, 32'hA5A5A5A5, 5'd9, 1'b0, 0, 32'h0);
    checks++;
    if (obs_hang || obs_req != 1 || obs_stall != 2) begin
      errors++; $display("FAIL store_cycles: got req=%0d stall=%0d hang=%b want 1 2 0", obs_req, obs_stall, obs_hang);
    end
    checks++;
    if ({obs_we, obs_sel, obs_addr, obs_wdata} !== {1'b1, 1'b0, 32'h10, 32'hA5A5A5A5}) begin
      errors++; $display("FAIL store_bus: got we=%b sel=%b addr=%h wdata=%h want 1 0 10 a5a5a5a5", obs_we, obs_sel, obs_addr, obs_wdata);
    end
    checks++;
    if ({obs_wreg_busy, obs_done_wreg} !== 2'b00) begin
      errors++; $display("FAIL store_wreg: got busy=%b done=%b want 0 0", obs_wreg_busy, obs_done_wreg);
    end
  endtask

  task automatic test_io_priority();
    exp_q.push_back({1'b0, 32'h7F});
    do_access(0, 0, 1, 1, 32'h2, 32'h55, 5'd4, 1'b1, 1, 32'h7F);
    checks++;
    if (obs_hang || {obs_sel, obs_we, obs_addr} !== {1'b1, 1'b0, 32'h2}) begin
      errors++; $display("FAIL io_in_wins: got sel=%b we=%b addr=%h want 1 0 2", obs_sel, obs_we, obs_addr);
    end
    // IO out alone: write to port, write-back keeps mem_wdata.
    exp_q.push_back({1'b0, 32'h0BAD_F00D});
    do_access(0, 0, 0, 1, 32'h3, 32'h0BAD_F00D, 5'd6, 1'b0, 0, 32'h1111);
    checks++;
    if (obs_hang || {obs_sel, obs_we, obs_wdata} !== {1'b1, 1'b1, 32'h0BAD_F00D}) begin
      errors++; $display("FAIL io_out: got sel=%b we=%b wdata=%h want 1 1 0badf00d", obs_sel, obs_we, obs_wdata);
    end
  endtask

  task automatic test_timeout();
    exp_q.push_back({1'b1, 32'h0});
    do_access(1, 0, 0, 0, 32'h44, 32'h0, 5'd1, 1'b1, -1, 32'h0);
    checks++;
    if (obs_hang || obs_req != TIMEOUT || obs_stall != TIMEOUT + 1 || !obs_stable) begin
      errors++; $display("FAIL to_cycles: got req=%0d stall=%0d stable=%b want %0d %0d 1", obs_req, obs_stall, obs_stable, TIMEOUT, TIMEOUT + 1);
    end
    @(negedge clk);
    checks++;
    if ({bus_err, stallreq_mem, bus_req, state_o} !== 5'b00000) begin
      errors++; $display("FAIL to_after: got err=%b stall=%b req=%b state=%0d want 0 0 0 0", bus_err, stallreq_mem, bus_req, state_o);
    end
    @(posedge clk);
    #1;
    // Ack on the last allowed REQ cycle beats the timeout.
    exp_q.push_back({1'b0, 32'h600D_DA7A});
    do_access(1, 0, 0, 0, 32'h48, 32'h0, 5'd2, 1'b1, TIMEOUT - 1, 32'h600D_DA7A);
    checks++;
    if (obs_hang || obs_req != TIMEOUT) begin
      errors++; $display("FAIL to_ack_wins: got req=%0d hang=%b want %0d 0", obs_req, obs_hang, TIMEOUT);
    end
  endtask

  task automatic test_reset_mid_req();
    exp_q.push_back({1'b0, 32'hCAFEF00D});
    mem_R = 1'b1; mem_addr = 32'h80; mem_wd = 5'd7; mem_wreg = 1'b1; mem_wdata = 32'h0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus_req, stallreq_mem, state_o} !== 4'b0000) begin
      errors++; $display("FAIL rst_mid: got req=%b stall=%b state=%0d want 0 0 0", bus_req, stallreq_mem, state_o);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({stallreq_mem, bus_req, state_o} !== 4'b1000) begin
      errors++; $display("FAIL rst_restart_idle: got stall=%b req=%b state=%0d want 1 0 0", stallreq_mem, bus_req, state_o);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus_req, bus_addr} !== {1'b1, 32'h80}) begin
      errors++; $display("FAIL rst_restart_req: got req=%b addr=%h want 1 80", bus_req, bus_addr);
    end
    bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    bus_ack = 1'b0;
    checks++;
    if ({stallreq_mem, wreg_o} !== 2'b01) begin
      errors++; $display("FAIL rst_restart_done: got stall=%b wreg=%b want 0 1", stallreq_mem, wreg_o);
    end
    @(posedge clk);
    #1;
    mem_R = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      d = $urandom();
      // R and W together: R wins, returns bus data.
      exp_q.push_back({1'b0, d});
      do_access(1, 1, 0, 0, 32'h100 + i, 32'h0, 5'(i), 1'b1, $urandom_range(0, 3), d);
      checks++;
      if (obs_hang || obs_first_req !== 1'b0 || obs_we !== 1'b0) begin
        errors++; $display("FAIL b2b_%0d: got first_req=%b we=%b hang=%b want 0 0 0", i, obs_first_req, obs_we, obs_hang);
      end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load();
    test_store();
    test_io_priority();
    test_timeout();
    test_reset_mid_req();
    test_back_to_back();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
